// File: rtl/uart_rx_deser_if.sv
// Parallel-side bundle of the UART RX deserializer: serial bit in, assembled word out.
interface uart_rx_deser_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sampled_bit;
  logic                  deser_en;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  p_data_ready;

  modport master (
    output sampled_bit,
    output deser_en,
    input  p_data,
    input  p_data_ready
  );

  modport slave (
    input  sampled_bit,
    input  deser_en,
    output p_data,
    output p_data_ready
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART RX serial-to-parallel: one bit per enabled clk, LSB first; word + 1-cycle strobe
// on the edge sampling the last bit (zero extra latency); deser_en low simply stalls the frame.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_deser_if.slave rx
);
  localparam int                CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_rx_deser: DATA_WIDTH must be in 5..9");
  end

  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted     = {rx.sampled_bit, shift_reg_q[DATA_WIDTH-1:1]};
    shift_reg_d = shift_reg_q;
    p_data_d    = p_data_q;
    bit_count_d = bit_count_q;
    ready_d     = 1'b0;
    if (rx.deser_en) begin
      shift_reg_d = shifted;
      // The completed word is taken from the shift result directly so it appears on this edge.
      if (bit_count_q == LAST) begin
        bit_count_d = '0;
        p_data_d    = shifted;
        ready_d     = 1'b1;
      end else begin
        bit_count_d = bit_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg_q <= '0;
      p_data_q    <= '0;
      bit_count_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      shift_reg_q <= shift_reg_d;
      p_data_q    <= p_data_d;
      bit_count_q <= bit_count_d;
      ready_q     <= ready_d;
    end
  end

  assign rx.p_data       = p_data_q;
  assign rx.p_data_ready = ready_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized + directed bench for uart_rx_deser with a queue-based scoreboard and bit-history model.
module tb_uart_rx_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_deser_if #(.DATA_WIDTH(W)) bus ();
  uart_rx_deser #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .rx(bus));

  int checks   = 0;
  int failures = 0;

  // Reference model: enabled bits since reset (last W kept) and position within the frame.
  logic [W-1:0] expq[$];
  bit           hist[$];
  int           nbits = 0;
  logic [W-1:0] hold_word = '0;
  logic [W-1:0] mon_exp;
  int           cyc = 0;
  int           rdy_cyc[$];
  logic         prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_shift();
    logic [W-1:0] e = '0;
    for (int j = 0; j < W && j < hist.size(); j++) e[W-1-j] = hist[hist.size()-1-j];
    return e;
  endfunction

  task automatic step(input bit en, input bit b);
    logic [W-1:0] word;
    @(negedge clk);
    bus.deser_en    = en;
    bus.sampled_bit = b;
    if (en) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      nbits++;
      if (nbits == W) begin
        word = '0;
        for (int i = 0; i < W; i++) word[i] = hist[i];
        expq.push_back(word);
        nbits = 0;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) step(1'b1, w[i]);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.deser_en = 1'b0;
    hist.delete();
    expq.delete();
    nbits = 0;
    #1;
    chk("rst_p_data", bus.p_data, 0);
    chk("rst_ready", bus.p_data_ready, 0);
    chk("rst_bit_count", dut.bit_count_q, 0);
    chk("rst_shift_reg", dut.shift_reg_q, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every strobe and checks hold/state the rest of the time.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) hold_word = '0;
    if (bus.p_data_ready) begin
      rdy_cyc.push_back(cyc);
      chk("ready_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        mon_exp = expq.pop_front();
        chk("p_data_word", bus.p_data, mon_exp);
        hold_word = mon_exp;
      end
      chk("ready_one_cycle", prev_rdy, 0);
    end else begin
      chk("p_data_hold", bus.p_data, hold_word);
    end
    prev_rdy = bus.p_data_ready;
    chk("bit_count", dut.bit_count_q, nbits);
    chk("shift_reg", dut.shift_reg_q, exp_shift());
  end

  logic [W-1:0] rw;
  int           n0;
  bit           t1 [8];

  initial begin
    rst = 1'b0;
    bus.deser_en = 1'b0;
    bus.sampled_bit = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_p_data", bus.p_data, 0);
    chk("init_ready", bus.p_data_ready, 0);
    chk("init_bit_count", dut.bit_count_q, 0);
    @(negedge clk);
    rst = 1'b1;

    // Frame 1,0,0,1,1,1,0,0 -> 0x39
    t1 = '{1, 0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t1[i]);
      after_edge();
      if (i == 2) begin
        rw = dut.shift_reg_q;
        chk("mid_shift_top3", {29'd0, rw[7:5]}, 32'h1);
        chk("mid_bit_count", dut.bit_count_q, 3);
      end
    end
    chk("f39_p_data", bus.p_data, 8'h39);
    chk("f39_ready_hi", bus.p_data_ready, 1);
    chk("f39_bit_count", dut.bit_count_q, 0);
    step(1'b0, 1'b0);
    after_edge();
    chk("f39_ready_lo", bus.p_data_ready, 0);

    // 0xA5 with a 3-cycle enable gap after bit 4
    n0 = rdy_cyc.size();
    for (int i = 0; i < 4; i++) step(1'b1, 1'((8'hA5 >> i) & 1));
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      after_edge();
      chk("gap_bit_count", dut.bit_count_q, 4);
    end
    for (int i = 4; i < 8; i++) step(1'b1, 1'((8'hA5 >> i) & 1));
    step(1'b0, 1'b0);
    after_edge();
    chk("gapA5_p_data", bus.p_data, 8'hA5);
    chk("gapA5_pulses", rdy_cyc.size() - n0, 1);

    // Back-to-back 0x55, 0xC3
    send_word(8'h55);
    send_word(8'hC3);
    step(1'b0, 1'b0);
    after_edge();
    n0 = rdy_cyc.size();
    chk("b2b_spacing", rdy_cyc[n0-1] - rdy_cyc[n0-2], 8);
    chk("b2b_p_data", bus.p_data, 8'hC3);

    // Reset after 5 bits, then 0x3C
    rw = 8'($urandom);
    for (int i = 0; i < 5; i++) step(1'b1, rw[i]);
    do_reset();
    send_word(8'h3C);
    step(1'b0, 1'b0);
    after_edge();
    chk("post_rst_3C", bus.p_data, 8'h3C);

    // Disabled with toggling input
    n0 = rdy_cyc.size();
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i & 1));
    after_edge();
    chk("idle_p_data", bus.p_data, 8'h3C);
    chk("idle_bit_count", dut.bit_count_q, 0);
    chk("idle_no_ready", rdy_cyc.size() - n0, 0);

    // Random traffic with occasional gaps and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    after_edge();
    chk("scoreboard_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
